paddle_ctrl: RTL and testbench

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/paddle_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_paddle_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// Two-player paddle controller: button synchronisers and debouncers,
// per-paddle direction FSM, and saturating position registers that move
// once per video frame.

// Synchroniser and debouncer for one push-button.
module paddle_deb #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic clk_in,
    input  logic i_rst,
    input  logic btn,
    output logic level
);

    logic        sync1;
    logic        sync2;
    logic [15:0] cnt;

    // Two-flop synchroniser, then accept a new level only once it has differed
    // from the accepted level for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk_in) begin
        if (i_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= 16'd0;
            level <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (cnt == DEB_CYCLES - 16'd1) begin
                    level <= sync2;
                    cnt   <= 16'd0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end else begin
                cnt <= 16'd0;
            end
        end
    end

endmodule

// Direction FSM and position register for one paddle.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no button, or both buttons: paddle holds
//   MOVE_UP | only up accepted: paddle rises STEP per frame
//   MOVE_DN | only down accepted: paddle falls STEP per frame
module paddle_axis #(
    parameter int STEP    = 4,
    parameter int Y_LIMIT = 390,
    parameter int Y_INIT  = 195
) (
    input  logic       clk_in,
    input  logic       i_rst,
    input  logic       up,
    input  logic       dn,
    input  logic       tick,
    input  logic       rc,
    output logic [8:0] pos,
    output logic       moving
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2
    } state_t;

    localparam logic [9:0] STEP_W = 10'(STEP);
    localparam logic [9:0] LIM_W  = 10'(Y_LIMIT);
    localparam logic [8:0] INIT_P = 9'(Y_INIT);

    state_t     state;
    logic [9:0] pos_w;
    logic [8:0] pos_nxt;

    // Next position: saturating arithmetic done 10 bits wide so neither end
    // can wrap; a pending recenter overrides any motion on the tick.
    always_comb begin
        pos_w   = {1'b0, pos};
        pos_nxt = pos;
        if (tick) begin
            if (rc) begin
                pos_nxt = INIT_P;
            end else begin
                unique case (state)
                    MOVE_UP: pos_nxt = (pos_w >= STEP_W) ? 9'(pos_w - STEP_W) : 9'd0;
                    MOVE_DN: pos_nxt = ((pos_w + STEP_W) <= LIM_W) ? 9'(pos_w + STEP_W)
                                                                     : 9'(LIM_W);
                    default: pos_nxt = pos;
                endcase
            end
        end
    end

    // State follows the accepted buttons every cycle; outputs are registered.
    always_ff @(posedge clk_in) begin
        if (i_rst) begin
            state  <= IDLE;
            pos    <= INIT_P;
            moving <= 1'b0;
        end else begin
            moving <= (state != IDLE);
            pos    <= pos_nxt;
            unique case ({up, dn})
                2'b10:   state <= MOVE_UP;
                2'b01:   state <= MOVE_DN;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// Top level: four debounced buttons, frame tick, recenter request, two paddles.
module paddle_ctrl #(
    parameter int          STEP       = 4,
    parameter int          BAR_H      = 90,
    parameter int          Y_MAX      = 390,
    parameter int          Y_INIT     = 195,
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic       clk_in,
    input  logic       i_rst,
    input  logic       btn_up1,
    input  logic       btn_dn1,
    input  logic       btn_up2,
    input  logic       btn_dn2,
    input  logic [9:0] o_x,
    input  logic [8:0] o_y,
    input  logic       recenter,
    output logic [8:0] pos_yBarra1,
    output logic [8:0] pos_yBarra2,
    output logic       moving1,
    output logic       moving2
);

    // Never let a misconfigured Y_MAX push the paddle bottom past line 479.
    localparam int Y_LIMIT = (Y_MAX < (480 - BAR_H)) ? Y_MAX : (480 - BAR_H);

    logic up1, dn1, up2, dn2;
    logic frame_match;
    logic match_d;
    logic tick;
    logic rc_pend;

    paddle_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up1 (
        .clk_in(clk_in), .i_rst(i_rst), .btn(btn_up1), .level(up1)
    );
    paddle_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn1 (
        .clk_in(clk_in), .i_rst(i_rst), .btn(btn_dn1), .level(dn1)
    );
    paddle_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up2 (
        .clk_in(clk_in), .i_rst(i_rst), .btn(btn_up2), .level(up2)
    );
    paddle_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn2 (
        .clk_in(clk_in), .i_rst(i_rst), .btn(btn_dn2), .level(dn2)
    );

    // One tick on the first cycle of the last-pixel match, however long it is held.
    always_comb begin
        frame_match = (o_x == 10'd639) && (o_y == 9'd479);
        tick        = frame_match && !match_d;
    end

    // Match history for edge detection, and the set-dominant recenter request.
    always_ff @(posedge clk_in) begin
        if (i_rst) begin
            match_d <= 1'b0;
            rc_pend <= 1'b0;
        end else begin
            match_d <= frame_match;
            if (recenter) begin
                rc_pend <= 1'b1;
            end else if (tick) begin
                rc_pend <= 1'b0;
            end
        end
    end

    paddle_axis #(.STEP(STEP), .Y_LIMIT(Y_LIMIT), .Y_INIT(Y_INIT)) u_axis1 (
        .clk_in(clk_in), .i_rst(i_rst), .up(up1), .dn(dn1), .tick(tick),
        .rc(rc_pend), .pos(pos_yBarra1), .moving(moving1)
    );

    paddle_axis #(.STEP(STEP), .Y_LIMIT(Y_LIMIT), .Y_INIT(Y_INIT)) u_axis2 (
        .clk_in(clk_in), .i_rst(i_rst), .up(up2), .dn(dn2), .tick(tick),
        .rc(rc_pend), .pos(pos_yBarra2), .moving(moving2)
    );

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl with a short debounce. A cycle model derived from the
// block's rules is checked every cycle; directed scenarios add literal checks.
module tb_paddle_ctrl;

    localparam int STEP   = 4;
    localparam int Y_MAX  = 390;
    localparam int Y_INIT = 195;
    localparam int DEB    = 4;

    logic       clk_in = 1'b0;
    logic       i_rst;
    logic       btn_up1, btn_dn1, btn_up2, btn_dn2;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       recenter;
    logic [8:0] pos_yBarra1, pos_yBarra2;
    logic       moving1, moving2;

    int total = 0;
    int bad   = 0;

    paddle_ctrl #(
        .STEP(STEP), .BAR_H(90), .Y_MAX(Y_MAX), .Y_INIT(Y_INIT), .DEB_CYCLES(16'(DEB))
    ) dut (
        .clk_in(clk_in), .i_rst(i_rst),
        .btn_up1(btn_up1), .btn_dn1(btn_dn1), .btn_up2(btn_up2), .btn_dn2(btn_dn2),
        .o_x(o_x), .o_y(o_y), .recenter(recenter),
        .pos_yBarra1(pos_yBarra1), .pos_yBarra2(pos_yBarra2),
        .moving1(moving1), .moving2(moving2)
    );

    always #5 clk_in = ~clk_in;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buttons indexed 0=up1 1=dn1 2=up2 3=dn2; dir is -1 (up), 0, +1 (down).
    bit m_valid = 0;
    int m_pos[2];
    int m_dir[2];
    int m_mov[2];
    int m_acc[4];
    int m_streak[4];
    int m_d1[4];
    int m_d2[4];
    int m_rc;
    int m_prev;

    always @(posedge clk_in) begin
        int raw[4];
        int m, tk, np;
        raw[0] = int'(btn_up1); raw[1] = int'(btn_dn1);
        raw[2] = int'(btn_up2); raw[3] = int'(btn_dn2);
        if (i_rst) begin
            m_valid = 1;
            for (int p = 0; p < 2; p++) begin
                m_pos[p] = Y_INIT; m_dir[p] = 0; m_mov[p] = 0;
            end
            for (int b = 0; b < 4; b++) begin
                m_acc[b] = 0; m_streak[b] = 0; m_d1[b] = 0; m_d2[b] = 0;
            end
            m_rc = 0; m_prev = 0;
        end else begin
            m  = (o_x == 10'd639 && o_y == 9'd479) ? 1 : 0;
            tk = (m == 1 && m_prev == 0) ? 1 : 0;
            for (int p = 0; p < 2; p++) begin
                if (tk == 1) begin
                    if (m_rc == 1) begin
                        m_pos[p] = Y_INIT;
                    end else begin
                        np = m_pos[p] + STEP * m_dir[p];
                        if (np < 0) np = 0;
                        if (np > Y_MAX) np = Y_MAX;
                        m_pos[p] = np;
                    end
                end
                m_mov[p] = (m_dir[p] != 0) ? 1 : 0;
            end
            if (recenter) m_rc = 1;
            else if (tk == 1) m_rc = 0;
            m_prev = m;
            for (int p = 0; p < 2; p++)
                m_dir[p] = m_acc[2*p + 1] - m_acc[2*p];
            for (int b = 0; b < 4; b++) begin
                if (m_d2[b] != m_acc[b]) begin
                    m_streak[b]++;
                    if (m_streak[b] == DEB) begin
                        m_acc[b] = m_d2[b];
                        m_streak[b] = 0;
                    end
                end else begin
                    m_streak[b] = 0;
                end
                m_d2[b] = m_d1[b];
                m_d1[b] = raw[b];
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_in) begin
        if (m_valid) begin
            cmp("pos1_model", int'(pos_yBarra1), m_pos[0]);
            cmp("pos2_model", int'(pos_yBarra2), m_pos[1]);
            cmp("moving1_model", int'(moving1), m_mov[0]);
            cmp("moving2_model", int'(moving2), m_mov[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        cyc(3);
        i_rst = 1'b0;
        cyc(1);
    endtask

    task automatic set_btns(input logic u1, input logic d1, input logic u2, input logic d2);
        btn_up1 = u1; btn_dn1 = d1; btn_up2 = u2; btn_dn2 = d2;
        cyc(10);
    endtask

    task automatic frame(input int hold);
        o_x = 10'd639; o_y = 9'd479;
        cyc(hold);
        o_x = 10'd0; o_y = 9'd0;
        cyc(3);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        btn_up1 = 0; btn_dn1 = 0; btn_up2 = 0; btn_dn2 = 0;
        o_x = 10'd0; o_y = 9'd0; recenter = 1'b0;
        do_reset();
        cmp("reset_pos1", int'(pos_yBarra1), 195);
        cmp("reset_pos2", int'(pos_yBarra2), 195);
        cmp("reset_moving1", int'(moving1), 0);

        // up1 held for three frames
        set_btns(1, 0, 0, 0);
        cmp("up1_moving", int'(moving1), 1);
        frame(1); cmp("up1_f1", int'(pos_yBarra1), 191);
        frame(1); cmp("up1_f2", int'(pos_yBarra1), 187);
        frame(1); cmp("up1_f3", int'(pos_yBarra1), 183);
        cmp("up1_pos2", int'(pos_yBarra2), 195);
        set_btns(0, 0, 0, 0);
        cmp("up1_release", int'(moving1), 0);

        // two-cycle glitch on dn2 is rejected
        btn_dn2 = 1; cyc(2); btn_dn2 = 0; cyc(10);
        cmp("glitch_moving2", int'(moving2), 0);
        frame(1);
        cmp("glitch_pos2", int'(pos_yBarra2), 195);

        // both buttons on paddle 2: no motion
        set_btns(0, 0, 1, 1);
        cmp("both_moving2", int'(moving2), 0);
        frames(3);
        cmp("both_pos2", int'(pos_yBarra2), 195);
        set_btns(0, 0, 0, 0);

        // saturation at both ends
        do_reset();
        set_btns(0, 1, 0, 0);
        frames(50); cmp("sat_hi_a", int'(pos_yBarra1), 390);
        frame(1);   cmp("sat_hi_b", int'(pos_yBarra1), 390);
        set_btns(1, 0, 0, 0);
        frames(97); cmp("reach_2", int'(pos_yBarra1), 2);
        frame(1);   cmp("sat_lo_a", int'(pos_yBarra1), 0);
        frame(1);   cmp("sat_lo_b", int'(pos_yBarra1), 0);
        set_btns(0, 1, 0, 0);
        frames(97); cmp("reach_388", int'(pos_yBarra1), 388);
        frame(1);   cmp("clamp_390", int'(pos_yBarra1), 390);
        frame(1);   cmp("stay_390", int'(pos_yBarra1), 390);

        // coordinates held for five cycles give exactly one step
        do_reset();
        set_btns(0, 1, 0, 0);
        frame(5); cmp("hold5_step", int'(pos_yBarra1), 199);
        frame(1); cmp("hold5_next", int'(pos_yBarra1), 203);

        // reset in the middle of a debounce leaves nothing behind
        set_btns(0, 0, 0, 0);
        btn_dn1 = 1; cyc(3);
        i_rst = 1; cyc(2);
        btn_dn1 = 0; i_rst = 0;
        cyc(10);
        frame(1);
        cmp("midreset_pos1", int'(pos_yBarra1), 195);
        cmp("midreset_mov1", int'(moving1), 0);

        // recenter with paddle 1 at 150 and up held
        set_btns(0, 1, 0, 0);
        frames(50);
        set_btns(1, 0, 0, 0);
        frames(60); cmp("at_150", int'(pos_yBarra1), 150);
        cyc(2);
        recenter = 1; cyc(1); recenter = 0; cyc(3);
        cmp("rc_wait", int'(pos_yBarra1), 150);
        frame(1); cmp("rc_tick", int'(pos_yBarra1), 195);
        cmp("rc_tick_p2", int'(pos_yBarra2), 195);
        frame(1); cmp("rc_after", int'(pos_yBarra1), 191);

        // recenter on the tick cycle itself is kept for the next tick
        o_x = 10'd639; o_y = 9'd479; recenter = 1;
        cyc(1);
        recenter = 0; o_x = 10'd0; o_y = 9'd0;
        cyc(3);
        cmp("rc_same_tick", int'(pos_yBarra1), 187);
        frame(1); cmp("rc_deferred", int'(pos_yBarra1), 195);

        set_btns(0, 0, 0, 0);
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
